vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Head of the VGA drawing chain. It generates the horizontal and vertical raster counters and the sync pulses, and drives the first `vga` chain link that every draw stage consumes, starting with the star field. Each draw stage relies on this block to present pixel (0,0) exactly once per frame. That pixel is the frame-start marker the stages use to reseed. By default it presents a black, not-enabled background.

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch/sync/porch, pixels
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch/sync/porch, lines
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- pxl_ce  in  1  pixel clock enable; one raster step per cycle with pxl_ce=1
- vga_chain_out  vga.out  —  chain link: t.pxl_x[10:0], t.pxl_y[10:0], t.hsync, t.vsync, t.active, t.red/green/blue[3:0], t.en
- frame_start  out  1  one-cycle pulse aligned with the chain output showing (0,0)

## Operation
- H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (800). V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP (525).
- h_cnt runs 0..H_TOTAL-1. It advances only when pxl_ce=1. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
- v_cnt runs 0..V_TOTAL-1. It wraps to 0 when h_cnt wraps and v_cnt=V_TOTAL-1.
- pxl_x=h_cnt and pxl_y=v_cnt, zero-extended to 11 bits. Values are not clamped during blanking, so (0,0) occurs once per frame.
- active = (h_cnt<WIDTH) && (v_cnt<HEIGHT).
- hsync = SYNC_ACTIVE when h_cnt is in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC-1] (656..751). Otherwise it is ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE when v_cnt is in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC-1] (490..491). It is evaluated on v_cnt, not per pixel.
- frame_start = 1 for the one cycle in which the output shows pxl_x=0, pxl_y=0 after a pxl_ce step or after reset release.
- Default colour output: red/green/blue=0, en=0. Downstream stages overlay on this.
- Counter comparisons are unsigned. Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL).

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0
  - pxl_x=0, pxl_y=0
  - hsync=vsync=~SYNC_ACTIVE
  - active=0
  - colours=0, en=0
  - frame_start=0
- All chain fields and frame_start are registered. Outputs reflect counter state with 1 cycle latency.
- First edge after reset release with pxl_ce=1: outputs show (0,0), active=1, frame_start=1. The counters then advance to h_cnt=1.
- pxl_ce=0: counters hold and all outputs hold their values, except frame_start, which drops to 0. No pixel is skipped or duplicated in the pxl_ce=1 sequence.
- Simultaneous h and v wrap at (799,524): the next output is (0,0) with frame_start=1.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous). The raster restarts at (0,0).

## Configuration
- VGA_TIMING_TEST_PATTERN_EN defined:
  - While active=1, the output drives 8 vertical colour bars, each WIDTH/8 px wide. Bar index b = h_cnt/(WIDTH/8).
  - red=b[2]?4'hf:0, green=b[1]?4'hf:0, blue=b[0]?4'hf:0, en=1.
  - During blanking: colours=0, en=0.
- Undefined: colours=0 and en=0 always. No divider logic is synthesised.

## Test plan
- Reset then pxl_ce=1 constant: pxl_x counts 0..799, then pxl_y=1. frame_start is high only at cycle 1 and at cycle 1+420000.
- hsync check: hsync=0 for exactly 96 cycles, starting when pxl_x=656, period 800. vsync=0 while pxl_y is 490 or 491. Period 420000 cycles.
- pxl_ce toggling 1,0,1,0: each pxl_x value is held for 2 cycles. frame_start is 1 for one cycle only. Sync widths are still 96/2 pxl_ce steps.
- Reset pulse at pxl_x=300, pxl_y=200: outputs are 0 immediately and hsync/vsync are inactive. After release the raster restarts at (0,0) with frame_start=1.
- active check: active=1 exactly for pxl_x<640 and pxl_y<480. 307200 active steps per frame.
- With VGA_TIMING_TEST_PATTERN_EN:
  - pxl_x=0 gives black, en=1.
  - pxl_x=80 gives blue=f.
  - pxl_x=639 gives white.
  - pxl_x=640 gives black, en=0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga chain link: pixel position, sync, active and colour bundle.
// Shared by the timing generator and every downstream draw stage.
package vga_pkg;

   typedef struct packed {
      logic [10:0] pxl_x;
      logic [10:0] pxl_y;
      logic        hsync;
      logic        vsync;
      logic        active;
      logic [3:0]  red;
      logic [3:0]  green;
      logic [3:0]  blue;
      logic        en;
   } vga_t;

endpackage

interface vga;
   import vga_pkg::*;

   vga_t t;

   modport out (output t);
   modport in  (input  t);

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync pulses and background chain link.
// Optional colour-bar background: define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   WIDTH       = 640,
   parameter int   HEIGHT      = 480,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_ACTIVE = 1'b0
)(
   input  logic clk,
   input  logic resetN,
   input  logic pxl_ce,
   vga.out      vga_chain_out,
   output logic frame_start
);

   localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
   localparam logic [HW-1:0] HS_BEG = HW'(WIDTH + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(WIDTH + H_FP + H_SYNC - 1);

   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
   localparam logic [VW-1:0] VS_BEG = VW'(HEIGHT + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(HEIGHT + V_FP + V_SYNC - 1);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   vga_t          t_q, t_d;
   logic          frame_start_q, frame_start_d;
   vga_t          pix;
   logic          pix_active;

   assign pix_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam int BAR_W = WIDTH / 8;

   logic [2:0] bar;

   assign bar = 3'(h_cnt_q / HW'(BAR_W));

   // Pixel bundle for the current counters, colour bars over the active area
   always_comb begin
      pix        = '0;
      pix.pxl_x  = 11'(h_cnt_q);
      pix.pxl_y  = 11'(v_cnt_q);
      pix.active = pix_active;
      pix.hsync  = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      pix.vsync  = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      if (pix_active) begin
         pix.red   = bar[2] ? 4'hf : 4'h0;
         pix.green = bar[1] ? 4'hf : 4'h0;
         pix.blue  = bar[0] ? 4'hf : 4'h0;
         pix.en    = 1'b1;
      end
   end
`else
   // Pixel bundle for the current counters over a black, disabled background
   always_comb begin
      pix        = '0;
      pix.pxl_x  = 11'(h_cnt_q);
      pix.pxl_y  = 11'(v_cnt_q);
      pix.active = pix_active;
      pix.hsync  = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      pix.vsync  = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END))
                 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end
`endif

   // Raster step: publish current pixel, then advance counters with wrap
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      t_d           = t_q;
      frame_start_d = 1'b0;
      if (pxl_ce) begin
         t_d           = pix;
         frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + 1'b1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset shows (0,0) with syncs idle and no colour
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         t_q           <= '0;
         t_q.hsync     <= ~SYNC_ACTIVE;
         t_q.vsync     <= ~SYNC_ACTIVE;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         t_q           <= t_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga_chain_out.t = t_q;
   assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 24x12 raster.
// Active 16x8, hsync at x 18..20, vsync at y 9..10, frame = 288 steps.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic resetN;
   logic pxl_ce;
   logic frame_start;

   vga vif ();

   vga_timing_gen #(
      .WIDTH (16), .HEIGHT(8),
      .H_FP  (2),  .H_SYNC(3), .H_BP(3),
      .V_FP  (1),  .V_SYNC(2), .V_BP(1),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .pxl_ce       (pxl_ce),
      .vga_chain_out(vif),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {chain bundle, frame_start} for a raster position
   function automatic logic [38:0] model(input int h, input int v,
                                          input bit fs);
      logic hs, vs, act;
      hs  = (h >= 18 && h <= 20) ? 1'b0 : 1'b1;
      vs  = (v >= 9 && v <= 10) ? 1'b0 : 1'b1;
      act = (h < 16) && (v < 8);
      return {11'(h), 11'(v), hs, vs, act, 12'h000, 1'b0, fs};
   endfunction

   task automatic tick(input bit ce);
      pxl_ce = ce;
      @(negedge clk);
   endtask

   function automatic logic [38:0] obs_all();
      return {vif.t, frame_start};
   endfunction

   logic [38:0] rst_val;
   logic [38:0] exp_v;
   logic [38:0] last_v;
   int mh, mv;
   int fs_cnt, act_cnt, hs_cnt, vs_cnt, hs_first;

   task automatic adv();
      if (mh == 23) begin
         mh = 0;
         mv = (mv == 11) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   initial begin
      rst_val = {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
      resetN  = 1'b0;
      pxl_ce  = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_all",    obs_all(),         rst_val);
      chk("rst_hsync",  vif.t.hsync,       1'b1);
      chk("rst_active", vif.t.active,      1'b0);
      chk("rst_fs",     frame_start,       1'b0);

      resetN = 1'b1;
      tick(1'b1);
      chk("first_x",      vif.t.pxl_x,  0);
      chk("first_y",      vif.t.pxl_y,  0);
      chk("first_active", vif.t.active, 1'b1);
      chk("first_fs",     frame_start,  1'b1);

      mh = 1; mv = 0;
      fs_cnt = 0; act_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs_first = -1;
      for (int i = 1; i <= 288; i++) begin
         tick(1'b1);
         exp_v = model(mh, mv, (mh == 0) && (mv == 0));
         chk("raster", obs_all(), exp_v);
         if (frame_start) fs_cnt++;
         if (vif.t.active) act_cnt++;
         if (!vif.t.hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(vif.t.pxl_x);
         end
         if (!vif.t.vsync) vs_cnt++;
         if (i == 24) begin
            chk("line2_x", vif.t.pxl_x, 0);
            chk("line2_y", vif.t.pxl_y, 1);
         end
         if (i == 288) begin
            chk("wrap_xy", {vif.t.pxl_x, vif.t.pxl_y}, 22'd0);
            chk("wrap_fs", frame_start, 1'b1);
         end
         adv();
      end
      chk("frame_fs_cnt",  fs_cnt,   1);
      chk("frame_active",  act_cnt,  128);
      chk("frame_hs_low",  hs_cnt,   36);
      chk("frame_vs_low",  vs_cnt,   48);
      chk("hsync_start_x", hs_first, 18);

      last_v = model(0, 0, 1'b1);
      fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      for (int j = 0; j < 576; j++) begin
         if (j % 2 == 0) begin
            tick(1'b0);
            exp_v = {last_v[38:1], 1'b0};
            chk("toggle_hold", obs_all(), exp_v);
         end else begin
            tick(1'b1);
            exp_v = model(mh, mv, (mh == 0) && (mv == 0));
            chk("toggle_step", obs_all(), exp_v);
            if (!vif.t.hsync) hs_cnt++;
            if (!vif.t.vsync) vs_cnt++;
            last_v = exp_v;
            adv();
         end
         if (frame_start) fs_cnt++;
      end
      chk("toggle_fs_cnt", fs_cnt, 1);
      chk("toggle_hs_low", hs_cnt, 36);
      chk("toggle_vs_low", vs_cnt, 48);

      for (int k = 0; k < 400; k++) begin
         if (mh == 11 && mv == 5) break;
         tick(1'b1);
         chk("pre_rst_step", obs_all(), model(mh, mv, (mh == 0) && (mv == 0)));
         adv();
      end
      chk("pre_rst_xy", {vif.t.pxl_x, vif.t.pxl_y}, {11'd10, 11'd5});

      #2 resetN = 1'b0;
      #1;
      chk("mid_rst_all", obs_all(), rst_val);
      @(negedge clk);
      chk("mid_rst_hold", obs_all(), rst_val);
      resetN = 1'b1;
      tick(1'b1);
      chk("restart_00", obs_all(), model(0, 0, 1'b1));
      tick(1'b1);
      chk("restart_10", obs_all(), model(1, 0, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
